mem_stage: RTL and testbench

Pipeline stage directly downstream of the execute stage. It consumes the ALU result as a load/store address or as a plain result, and consumes the forwarded rs2 value as store data. It runs a ready/valid transaction with the data memory, aligns store bytes, extracts and sign/zero-extends load data, and drives the registered `writeback` value that execute forwards back. It stalls upstream while a memory access is outstanding.

---
 rtl/mem_stage_pkg.sv | 43 ++++
 rtl/mem_stage_load_align.sv | 28 ++
 rtl/mem_stage.sv | 176 +++++++++++++++++
 tb/tb_mem_stage.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - opcodes, size codes, writeback selects and FSM states for mem_stage
package mem_stage_pkg;

  localparam int DATA_W = 32;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_CSR   = 7'b1110011;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    WB_ALU     = 2'd0,
    WB_LOAD    = 2'd1,
    WB_PC4     = 2'd2,
    WB_ALU_ALT = 2'd3
  } wb_sel_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  function automatic logic [DATA_W-1:0] wb_mux(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] alu,
    input logic [DATA_W-1:0] load,
    input logic [DATA_W-1:0] pc4
  );
    logic [DATA_W-1:0] res;
    case (sel)
      WB_LOAD: res = load;
      WB_PC4:  res = pc4;
      default: res = alu;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// rtl/mem_stage_load_align.sv - load_align: lane-shifts a raw load word and sign/zero-extends it
module load_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]        i_offset,
  input  logic [2:0]        i_funct3,
  input  logic [DATA_W-1:0] i_raw,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W-1:0] w_shifted;
  logic              w_byte_sign;
  logic              w_half_sign;

  assign w_shifted   = i_raw >> {i_offset, 3'b000};
  assign w_byte_sign = i_funct3[2] ? 1'b0 : w_shifted[7];
  assign w_half_sign = i_funct3[2] ? 1'b0 : w_shifted[15];

  always_comb begin
    o_data = w_shifted;
    case (i_funct3[1:0])
      SZ_BYTE: o_data = {{24{w_byte_sign}}, w_shifted[7:0]};
      SZ_HALF: o_data = {{16{w_half_sign}}, w_shifted[15:0]};
      default: o_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory stage: dmem ready/valid access, store lane alignment, load extension, writeback
// Optional misaligned-access trap: define MEM_MISALIGN_CHECK_EN.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN = DATA_W
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_valid_in,
  input  logic [31:0]     i_instruction,
  input  logic [XLEN-1:0] i_alu_result,
  input  logic [XLEN-1:0] i_store_data,
  input  logic [XLEN-1:0] i_pc,
  input  logic [1:0]      i_wb_select,
  output logic            o_stall,
  output logic            o_dmem_req_valid,
  input  logic            i_dmem_req_ready,
  output logic [XLEN-1:0] o_dmem_addr,
  output logic [XLEN-1:0] o_dmem_wdata,
  output logic [3:0]      o_dmem_wmask,
  input  logic            i_dmem_resp_valid,
  input  logic [XLEN-1:0] i_dmem_resp_data,
  output logic [XLEN-1:0] o_writeback,
  output logic            o_wb_valid,
  output logic [4:0]      o_wb_rd,
  output logic            o_misaligned
);

  logic [1:0]      r_state;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_pc4;
  logic [XLEN-1:0] r_wb;
  logic [3:0]      r_wmask;
  logic [2:0]      r_funct3;
  logic [4:0]      r_rd;
  logic [4:0]      r_wb_rd;
  logic [1:0]      r_wb_sel;
  logic            r_is_load;
  logic            r_wb_valid;
  logic            r_misaligned;

  logic [6:0]      w_opcode;
  logic [4:0]      w_rd;
  logic [2:0]      w_funct3;
  logic [1:0]      w_offset;
  logic            w_is_load;
  logic            w_is_store;
  logic            w_is_mem;
  logic            w_misalign;
  logic [3:0]      w_wmask;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_pc4;
  logic [XLEN-1:0] w_load_data;
  logic            w_unused_bits;

  assign w_opcode      = i_instruction[6:0];
  assign w_rd          = i_instruction[11:7];
  assign w_funct3      = i_instruction[14:12];
  assign w_unused_bits = ^i_instruction[31:15];
  assign w_offset      = i_alu_result[1:0];
  assign w_is_load     = (w_opcode == OP_LOAD);
  assign w_is_store    = (w_opcode == OP_STORE);
  assign w_is_mem      = w_is_load | w_is_store;
  assign w_pc4         = i_pc + XLEN'(4);

  // Lanes shifted past bit 31 fall off the 4-bit mask / 32-bit data.
  always_comb begin
    w_wmask = 4'b1111;
    case (w_funct3[1:0])
      SZ_BYTE: w_wmask = 4'b0001 << w_offset;
      SZ_HALF: w_wmask = 4'b0011 << w_offset;
      default: w_wmask = 4'b1111;
    endcase
  end

  assign w_wdata = i_store_data << {w_offset, 3'b000};

`ifdef MEM_MISALIGN_CHECK_EN
  assign w_misalign = ((w_funct3[1:0] == SZ_HALF) && w_offset[0]) ||
                      (w_funct3[1] && (w_offset != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  load_align u_load_align (
    .i_offset (r_addr[1:0]),
    .i_funct3 (r_funct3),
    .i_raw    (i_dmem_resp_data),
    .o_data   (w_load_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_pc4        <= '0;
      r_wb         <= '0;
      r_wmask      <= '0;
      r_funct3     <= '0;
      r_rd         <= '0;
      r_wb_rd      <= '0;
      r_wb_sel     <= '0;
      r_is_load    <= 1'b0;
      r_wb_valid   <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_wb_valid   <= 1'b0;
      r_misaligned <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_valid_in && w_is_mem) begin
            r_addr    <= i_alu_result;
            r_wdata   <= w_wdata;
            r_wmask   <= w_is_store ? w_wmask : 4'b0000;
            r_funct3  <= w_funct3;
            r_rd      <= w_is_load ? w_rd : 5'd0;
            r_pc4     <= w_pc4;
            r_wb_sel  <= i_wb_select;
            r_is_load <= w_is_load;
            if (w_misalign) begin
              r_state      <= ST_DONE;
              r_wb         <= '0;
              r_wb_rd      <= 5'd0;
              r_wb_valid   <= 1'b1;
              r_misaligned <= 1'b1;
            end else begin
              r_state <= ST_REQ;
            end
          end else if (i_valid_in) begin
            r_wb       <= wb_mux(i_wb_select, i_alu_result, i_alu_result, w_pc4);
            r_wb_rd    <= w_rd;
            r_wb_valid <= 1'b1;
          end
        end
        ST_REQ: begin
          if (i_dmem_req_ready) begin
            if (r_is_load) begin
              r_state <= ST_RESP;
            end else begin
              r_state    <= ST_DONE;
              r_wb       <= '0;
              r_wb_rd    <= 5'd0;
              r_wb_valid <= 1'b1;
            end
          end
        end
        ST_RESP: begin
          if (i_dmem_resp_valid) begin
            r_state    <= ST_DONE;
            r_wb       <= wb_mux(r_wb_sel, r_addr, w_load_data, r_pc4);
            r_wb_rd    <= r_rd;
            r_wb_valid <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // DONE holds stall low so upstream advances past the finished instruction.
  assign o_stall = (r_state == ST_REQ) || (r_state == ST_RESP) ||
                   ((r_state == ST_IDLE) && i_valid_in && w_is_mem);

  assign o_dmem_req_valid = (r_state == ST_REQ);
  assign o_dmem_addr      = {r_addr[XLEN-1:2], 2'b00};
  assign o_dmem_wdata     = r_wdata;
  assign o_dmem_wmask     = r_wmask;
  assign o_writeback      = r_wb;
  assign o_wb_valid       = r_wb_valid;
  assign o_wb_rd          = r_wb_rd;
  assign o_misaligned     = r_misaligned;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed scoreboard bench for mem_stage
module tb_mem_stage;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;

  typedef struct {
    logic [31:0] wb;
    logic [4:0]  rd;
    logic        mis;
    logic        chk_wb;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [31:0] instruction;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [31:0] pc;
  logic [1:0]  wb_select;
  logic        stall;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wmask;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [31:0] writeback;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        misaligned;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  mem_stage dut (
    .i_clk             (clk),
    .i_reset           (reset),
    .i_valid_in        (valid_in),
    .i_instruction     (instruction),
    .i_alu_result      (alu_result),
    .i_store_data      (store_data),
    .i_pc              (pc),
    .i_wb_select       (wb_select),
    .o_stall           (stall),
    .o_dmem_req_valid  (req_valid),
    .i_dmem_req_ready  (req_ready),
    .o_dmem_addr       (dmem_addr),
    .o_dmem_wdata      (dmem_wdata),
    .o_dmem_wmask      (dmem_wmask),
    .i_dmem_resp_valid (resp_valid),
    .i_dmem_resp_data  (resp_data),
    .o_writeback       (writeback),
    .o_wb_valid        (wb_valid),
    .o_wb_rd           (wb_rd),
    .o_misaligned      (misaligned)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: every writeback pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && wb_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_wb_valid", {31'd0, wb_valid}, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.chk_wb) chk("wb_data", writeback, e.wb);
        chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
        chk("wb_misaligned", {31'd0, misaligned}, {31'd0, e.mis});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic alu_op(input logic [31:0] alu, input logic [31:0] pcv, input logic [1:0] sel,
                        input logic [4:0] rd, input logic [31:0] exp, input string tag);
    valid_in    = 1'b1;
    instruction = {17'h0, 3'b000, rd, OPC_OP};
    alu_result  = alu;
    pc          = pcv;
    wb_select   = sel;
    q.push_back('{exp, rd, 1'b0, 1'b1});
    #1;
    chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
    tick();
    valid_in = 1'b0;
    chk({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd1);
    chk({tag, "_stall_after"}, {31'd0, stall}, 32'd0);
  endtask

  task automatic mem_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] emask, input logic [31:0] ewdata, input int rdy_wait,
                           input string tag);
    valid_in    = 1'b1;
    instruction = {17'h0, f3, 5'd3, OPC_STORE};
    alu_result  = addr;
    store_data  = data;
    wb_select   = 2'd0;
    req_ready   = (rdy_wait == 0);
    q.push_back('{32'h0, 5'd0, 1'b0, 1'b0});
    #1;
    chk({tag, "_c0_stall"}, {31'd0, stall}, 32'd1);
    chk({tag, "_c0_req"}, {31'd0, req_valid}, 32'd0);
    tick();
    for (int k = 0; k < rdy_wait; k++) begin
      chk({tag, "_wait_req"}, {31'd0, req_valid}, 32'd1);
      chk({tag, "_wait_mask"}, {28'd0, dmem_wmask}, {28'd0, emask});
      chk({tag, "_wait_stall"}, {31'd0, stall}, 32'd1);
      tick();
    end
    req_ready = 1'b1;
    #1;
    chk({tag, "_req"}, {31'd0, req_valid}, 32'd1);
    chk({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
    chk({tag, "_mask"}, {28'd0, dmem_wmask}, {28'd0, emask});
    chk({tag, "_wdata"}, dmem_wdata, ewdata);
    chk({tag, "_req_stall"}, {31'd0, stall}, 32'd1);
    tick();
    req_ready = 1'b0;
    chk({tag, "_done_wb_valid"}, {31'd0, wb_valid}, 32'd1);
    chk({tag, "_done_stall"}, {31'd0, stall}, 32'd0);
    chk({tag, "_done_req"}, {31'd0, req_valid}, 32'd0);
    valid_in = 1'b0;
    tick();
  endtask

  task automatic mem_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] resp,
                          input logic [4:0] rd, input int rdy_wait, input int resp_wait,
                          input logic [31:0] exp_wb, input string tag);
    valid_in    = 1'b1;
    instruction = {17'h0, f3, rd, OPC_LOAD};
    alu_result  = addr;
    store_data  = 32'h5555_5555;
    wb_select   = 2'd1;
    req_ready   = 1'b0;
    q.push_back('{exp_wb, rd, 1'b0, 1'b1});
    #1;
    chk({tag, "_c0_stall"}, {31'd0, stall}, 32'd1);
    tick();
    for (int k = 0; k < rdy_wait; k++) begin
      resp_valid = 1'b1;
      resp_data  = 32'hDEAD_BEEF;
      #1;
      chk({tag, "_wait_req"}, {31'd0, req_valid}, 32'd1);
      chk({tag, "_wait_addr"}, dmem_addr, {addr[31:2], 2'b00});
      chk({tag, "_wait_mask"}, {28'd0, dmem_wmask}, 32'd0);
      chk({tag, "_wait_stall"}, {31'd0, stall}, 32'd1);
      tick();
    end
    resp_valid = 1'b0;
    resp_data  = 32'h0;
    req_ready  = 1'b1;
    #1;
    chk({tag, "_req"}, {31'd0, req_valid}, 32'd1);
    chk({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
    tick();
    req_ready = 1'b0;
    for (int k = 0; k < resp_wait; k++) begin
      chk({tag, "_resp_wait_stall"}, {31'd0, stall}, 32'd1);
      chk({tag, "_resp_wait_req"}, {31'd0, req_valid}, 32'd0);
      tick();
    end
    resp_valid = 1'b1;
    resp_data  = resp;
    #1;
    chk({tag, "_resp_stall"}, {31'd0, stall}, 32'd1);
    tick();
    resp_valid = 1'b0;
    resp_data  = 32'h0;
    chk({tag, "_done_wb_valid"}, {31'd0, wb_valid}, 32'd1);
    chk({tag, "_done_stall"}, {31'd0, stall}, 32'd0);
    valid_in = 1'b0;
    tick();
  endtask

  initial begin
    reset       = 1'b1;
    valid_in    = 1'b0;
    instruction = 32'h0;
    alu_result  = 32'h0;
    store_data  = 32'h0;
    pc          = 32'h0;
    wb_select   = 2'd0;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_data   = 32'h0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_req_valid", {31'd0, req_valid}, 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_wmask", {28'd0, dmem_wmask}, 32'd0);
    chk("rst_writeback", writeback, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("rst_misaligned", {31'd0, misaligned}, 32'd0);
    tick();

    alu_op(32'h0000_1234, 32'h0000_0400, 2'd0, 5'd5, 32'h0000_1234, "add");
    tick();
    alu_op(32'h0000_0777, 32'h0000_1000, 2'd2, 5'd1, 32'h0000_1004, "jal_pc4");
    alu_op(32'hCAFE_0001, 32'h0000_2000, 2'd3, 5'd31, 32'hCAFE_0001, "sel3_b2b");
    tick();

    mem_store(3'b000, 32'h0000_0103, 32'h0000_00AB, 4'b1000, 32'hAB00_0000, 0, "sb");
    mem_store(3'b001, 32'h0000_0202, 32'h1234_ABCD, 4'b1100, 32'hABCD_0000, 2, "sh");
    mem_store(3'b010, 32'h0000_0304, 32'h8765_4321, 4'b1111, 32'h8765_4321, 1, "sw");
`ifndef MEM_MISALIGN_CHECK_EN
    mem_store(3'b001, 32'h0000_0403, 32'h0000_BEEF, 4'b1000, 32'hEF00_0000, 0, "sh_spill");
`endif

    mem_load(3'b000, 32'h0000_0002, 32'h0080_0000, 5'd6, 0, 0, 32'hFFFF_FF80, "lb");
    mem_load(3'b100, 32'h0000_0002, 32'h0080_0000, 5'd7, 0, 0, 32'h0000_0080, "lbu");
    mem_load(3'b001, 32'h0000_0000, 32'h1234_8001, 5'd8, 3, 2, 32'hFFFF_8001, "lh");
    mem_load(3'b101, 32'h0000_0012, 32'h8001_7FFF, 5'd9, 0, 1, 32'h0000_8001, "lhu");
    mem_load(3'b010, 32'h0000_0028, 32'hCAFE_BABE, 5'd10, 1, 0, 32'hCAFE_BABE, "lw");

    valid_in    = 1'b1;
    instruction = {17'h0, 3'b001, 5'd11, OPC_LOAD};
    alu_result  = 32'h0000_0010;
    wb_select   = 2'd1;
    tick();
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    chk("rst_mid_resp_stall", {31'd0, stall}, 32'd1);
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    valid_in = 1'b0;
    #1;
    chk("rst_mid_stall", {31'd0, stall}, 32'd0);
    chk("rst_mid_req", {31'd0, req_valid}, 32'd0);
    resp_valid = 1'b1;
    resp_data  = 32'h1111_2222;
    tick();
    resp_valid = 1'b0;
    chk("rst_mid_no_wb", {31'd0, wb_valid}, 32'd0);
    tick();
    chk("rst_mid_no_wb2", {31'd0, wb_valid}, 32'd0);
    alu_op(32'h0000_0042, 32'h0, 2'd0, 5'd12, 32'h0000_0042, "after_rst");
    tick();

`ifdef MEM_MISALIGN_CHECK_EN
    valid_in    = 1'b1;
    instruction = {17'h0, 3'b010, 5'd13, OPC_LOAD};
    alu_result  = 32'h0000_0006;
    wb_select   = 2'd1;
    req_ready   = 1'b1;
    q.push_back('{32'h0, 5'd0, 1'b1, 1'b0});
    #1;
    chk("mis_req_c0", {31'd0, req_valid}, 32'd0);
    tick();
    valid_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("mis_no_req", {31'd0, req_valid}, 32'd0);
      tick();
    end
    req_ready = 1'b0;
`endif

    tick();
    tick();
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
